// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: opcodes, functs, ALU ops,
// multicycle FSM states and datapath mux selects.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  localparam logic       SRC_A_PC       = 1'b0;
  localparam logic       SRC_A_REG      = 1'b1;
  localparam logic [1:0] SRC_B_REG      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_IMM      = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2  = 2'b11;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  localparam logic       ADDR_PC        = 1'b0;
  localparam logic       ADDR_ALUOUT    = 1'b1;
  localparam logic       REG_DST_RT     = 1'b0;
  localparam logic       REG_DST_RD     = 1'b1;
  localparam logic       WB_ALUOUT      = 1'b0;
  localparam logic       WB_MDR         = 1'b1;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU op translation; shared with the single-cycle control.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_valid
);

  // Unknown functs fall back to ADD so the datapath sees a harmless operation.
  always_comb begin
    alu_op      = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_NOR:  alu_op = ALU_NOR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and strobe.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int ALU_OP_W     = 4,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zf,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic                pc_en,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                illegal,
  output logic [3:0]          state_dbg
);

  state_t     state_q, state_d;
  logic [3:0] dec_alu_op;
  logic       dec_funct_valid;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_op      (dec_alu_op),
    .funct_valid (dec_funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = ST_FETCH;
    alu_op     = ALU_ADD;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    pc_en      = 1'b0;
    i_or_d     = ADDR_PC;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = WB_ALUOUT;
    reg_write  = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_en     = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        // Speculatively form the branch target; BRANCH consumes it from ALUOut.
        alu_src_b = SRC_B_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default: begin
            state_d = ST_FETCH;
            illegal = TRAP_ILLEGAL;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        i_or_d   = ADDR_ALUOUT;
        mem_read = 1'b1;
        state_d  = ST_MEMWB;
      end
      ST_MEMWB: begin
        mem_to_reg = WB_MDR;
        reg_write  = 1'b1;
      end
      ST_MEMWR: begin
        i_or_d    = ADDR_ALUOUT;
        mem_write = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = SRC_A_REG;
        alu_op    = dec_alu_op;
        if (dec_funct_valid) begin
          state_d = ST_ALUWB;
        end else begin
          state_d = ST_FETCH;
          illegal = TRAP_ILLEGAL;
        end
      end
      ST_ALUWB: begin
        reg_dst   = REG_DST_RD;
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = SRC_A_REG;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_en     = zf;
      end
      ST_ADDIEX: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_d   = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        reg_write = 1'b1;
      end
      ST_JUMP: begin
        pc_src = PC_SRC_JUMP;
        pc_en  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase

    // Reset masks everything so an aborted instruction leaves no partial writes.
    if (!rst_n) begin
      alu_op     = ALU_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      state_d    = ST_FETCH;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for mips_multicycle_ctrl; a second instance with
// TRAP_ILLEGAL=0 runs the same vectors and must never raise illegal.
module tb_mips_multicycle_ctrl;

  typedef struct {
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zf;
    logic [21:0] exp;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zf;

  logic [3:0]  alu_op, alu_op_nt;
  logic        alu_src_a, alu_src_a_nt;
  logic [1:0]  alu_src_b, alu_src_b_nt;
  logic [1:0]  pc_src, pc_src_nt;
  logic        pc_en, pc_en_nt, i_or_d, i_or_d_nt;
  logic        mem_read, mem_read_nt, mem_write, mem_write_nt;
  logic        ir_write, ir_write_nt, reg_dst, reg_dst_nt;
  logic        mem_to_reg, mem_to_reg_nt, reg_write, reg_write_nt;
  logic        illegal, illegal_nt;
  logic [3:0]  state_dbg, state_dbg_nt;

  int checks;
  int errors;
  vec_t vecs[$];

  mips_multicycle_ctrl #(.ALU_OP_W(4), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zf(zf),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  mips_multicycle_ctrl #(.ALU_OP_W(4), .TRAP_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zf(zf),
    .alu_op(alu_op_nt), .alu_src_a(alu_src_a_nt), .alu_src_b(alu_src_b_nt),
    .pc_src(pc_src_nt), .pc_en(pc_en_nt), .i_or_d(i_or_d_nt),
    .mem_read(mem_read_nt), .mem_write(mem_write_nt), .ir_write(ir_write_nt),
    .reg_dst(reg_dst_nt), .mem_to_reg(mem_to_reg_nt),
    .reg_write(reg_write_nt), .illegal(illegal_nt), .state_dbg(state_dbg_nt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed layout: state, alu_op, src_a, src_b, pc_src, pc_en, i_or_d,
  // mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal.
  function automatic logic [21:0] mk(input logic [3:0] st, input logic [3:0] alu,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic pe,
                                     input logic iord, input logic mr,
                                     input logic mw, input logic irw,
                                     input logic rd, input logic m2r,
                                     input logic rw, input logic ill);
    return {st, alu, sa, sb, ps, pe, iord, mr, mw, irw, rd, m2r, rw, ill};
  endfunction

  task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [21:0] e, input string nm);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.funct = fn; v.zf = z; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n  = v.rst_n;
    opcode = v.opcode;
    funct  = v.funct;
    zf     = v.zf;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [21:0] act, act_nt, exp_nt;
    act = {state_dbg, alu_op, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal};
    act_nt = {state_dbg_nt, alu_op_nt, alu_src_a_nt, alu_src_b_nt, pc_src_nt,
              pc_en_nt, i_or_d_nt, mem_read_nt, mem_write_nt, ir_write_nt,
              reg_dst_nt, mem_to_reg_nt, reg_write_nt, illegal_nt};
    exp_nt = v.exp & ~22'h1;
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", v.name, act, v.exp);
    end
    checks++;
    if (act_nt !== exp_nt) begin
      errors++;
      $display("[TB] FAIL %s (no trap): got %b expected %b", v.name, act_nt, exp_nt);
    end
  endtask

  initial begin
    logic [21:0] e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
    logic [21:0] e_aluwb, e_br1, e_br0, e_addiex, e_addiwb, e_jump;
    checks = 0;
    errors = 0;

    e_fetch  = mk(4'd0,  4'b0010, 1'b0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    e_decode = mk(4'd1,  4'b0010, 1'b0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_memadr = mk(4'd2,  4'b0010, 1'b1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_memrd  = mk(4'd3,  4'b0010, 1'b0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    e_memwb  = mk(4'd4,  4'b0010, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    e_memwr  = mk(4'd5,  4'b0010, 1'b0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    e_aluwb  = mk(4'd7,  4'b0010, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    e_br1    = mk(4'd8,  4'b0110, 1'b1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    e_br0    = mk(4'd8,  4'b0110, 1'b1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_addiex = mk(4'd9,  4'b0010, 1'b1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_addiwb = mk(4'd10, 4'b0010, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    e_jump   = mk(4'd11, 4'b0010, 1'b0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    push(0, 6'b100011, 6'h00, 0, mk(4'd0, 4'b0010, 0, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "reset idle");

    push(1, 6'b100011, 6'h00, 0, e_fetch,  "lw c1 fetch");
    push(1, 6'b100011, 6'h00, 0, e_decode, "lw c2 decode");
    push(1, 6'b100011, 6'h00, 0, e_memadr, "lw c3 memadr");
    push(1, 6'b100011, 6'h00, 0, e_memrd,  "lw c4 memrd");
    push(1, 6'b100011, 6'h00, 0, e_memwb,  "lw c5 memwb");

    push(1, 6'b000000, 6'b100111, 0, e_fetch,  "nor fetch");
    push(1, 6'b000000, 6'b100111, 0, e_decode, "nor decode");
    push(1, 6'b000000, 6'b100111, 0, mk(4'd6, 4'b1100, 1, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "nor exec");
    push(1, 6'b000000, 6'b100111, 0, e_aluwb,  "nor aluwb");
    push(1, 6'b000000, 6'b101010, 0, e_fetch,  "slt fetch");
    push(1, 6'b000000, 6'b101010, 0, e_decode, "slt decode");
    push(1, 6'b000000, 6'b101010, 0, mk(4'd6, 4'b0111, 1, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "slt exec");
    push(1, 6'b000000, 6'b101010, 0, e_aluwb,  "slt aluwb");
    push(1, 6'b000000, 6'b100000, 0, e_fetch,  "add fetch");
    push(1, 6'b000000, 6'b100000, 0, e_decode, "add decode");
    push(1, 6'b000000, 6'b100000, 0, mk(4'd6, 4'b0010, 1, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "add exec");
    push(1, 6'b000000, 6'b100000, 0, e_aluwb,  "add aluwb");
    push(1, 6'b000000, 6'b100010, 0, e_fetch,  "sub fetch");
    push(1, 6'b000000, 6'b100010, 0, e_decode, "sub decode");
    push(1, 6'b000000, 6'b100010, 0, mk(4'd6, 4'b0110, 1, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "sub exec");
    push(1, 6'b000000, 6'b100010, 0, e_aluwb,  "sub aluwb");
    push(1, 6'b000000, 6'b100100, 0, e_fetch,  "and fetch");
    push(1, 6'b000000, 6'b100100, 0, e_decode, "and decode");
    push(1, 6'b000000, 6'b100100, 0, mk(4'd6, 4'b0000, 1, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "and exec");
    push(1, 6'b000000, 6'b100100, 0, e_aluwb,  "and aluwb");
    push(1, 6'b000000, 6'b100101, 0, e_fetch,  "or fetch");
    push(1, 6'b000000, 6'b100101, 0, e_decode, "or decode");
    push(1, 6'b000000, 6'b100101, 0, mk(4'd6, 4'b0001, 1, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "or exec");
    push(1, 6'b000000, 6'b100101, 0, e_aluwb,  "or aluwb");

    push(1, 6'b000100, 6'h00, 1, e_fetch,  "beq taken fetch");
    push(1, 6'b000100, 6'h00, 1, e_decode, "beq taken decode");
    push(1, 6'b000100, 6'h00, 1, e_br1,    "beq taken branch");
    push(1, 6'b000100, 6'h00, 1, e_fetch,  "beq not-taken fetch");
    push(1, 6'b000100, 6'h00, 1, e_decode, "beq not-taken decode");
    push(1, 6'b000100, 6'h00, 0, e_br0,    "beq not-taken branch");

    push(1, 6'b001000, 6'h00, 0, e_fetch,  "addi fetch");
    push(1, 6'b001000, 6'h00, 0, e_decode, "addi decode");
    push(1, 6'b001000, 6'h00, 0, e_addiex, "addi exec");
    push(1, 6'b001000, 6'h00, 0, e_addiwb, "addi wb");

    push(1, 6'b000010, 6'h00, 0, e_fetch,  "j fetch");
    push(1, 6'b000010, 6'h00, 0, e_decode, "j decode");
    push(1, 6'b000010, 6'h00, 0, e_jump,   "j jump");

    push(1, 6'b101011, 6'h00, 0, e_fetch,  "sw fetch");
    push(1, 6'b101011, 6'h00, 0, e_decode, "sw decode");
    push(1, 6'b101011, 6'h00, 0, e_memadr, "sw memadr");
    push(1, 6'b101011, 6'h00, 0, e_memwr,  "sw memwr");

    push(1, 6'b111111, 6'h00, 0, e_fetch,         "badop fetch");
    push(1, 6'b111111, 6'h00, 0, e_decode | 22'h1, "badop decode");
    push(1, 6'b000000, 6'b000001, 0, e_fetch,    "badop back to fetch");
    push(1, 6'b000000, 6'b000001, 0, e_decode,   "badfn decode");
    push(1, 6'b000000, 6'b000001, 0, mk(4'd6, 4'b0010, 1, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,1), "badfn exec");

    push(1, 6'b100011, 6'h00, 0, e_fetch,  "abort lw fetch");
    push(1, 6'b100011, 6'h00, 0, e_decode, "abort lw decode");
    push(1, 6'b100011, 6'h00, 0, e_memadr, "abort lw memadr");
    push(0, 6'b100011, 6'h00, 0, mk(4'd3, 4'b0010, 0, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "reset in memrd");
    push(0, 6'b100011, 6'h00, 0, mk(4'd0, 4'b0010, 0, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "reset hold 2");
    push(0, 6'b100011, 6'h00, 0, mk(4'd0, 4'b0010, 0, 2'b00, 2'b00, 0,0,0,0,0,0,0,0,0), "reset hold 3");
    push(1, 6'b100011, 6'h00, 0, e_fetch,  "post-reset fetch");
    push(1, 6'b100011, 6'h00, 0, e_decode, "post-reset decode");

    rst_n  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h00;
    zf     = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i]);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
